dma_engine: RTL and testbench

Burst DMA controller sitting directly upstream of the bank crossbar's DMA port. It accepts one command at a time (direction, global word address, length) and walks the global address space. Write bursts are taken from a valid/ready input stream. Read bursts return data on a valid/ready output stream. Each global address is split into a 2-bit bank select and an ADDR_W-bit local address, which drive the crossbar's DMA override path.

---
 rtl/dma_engine.sv | 162 ++++++++++++++++
 tb/tb_dma_engine.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_engine.sv
`default_nettype none
// ============================================================================
// Module   : dma_engine
// Purpose  : Single-command burst DMA between valid/ready streams and the
//            banked memory crossbar's DMA override port.
// Revision : 1.0 - initial release
// ============================================================================
module dma_engine #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int NB     = 4,
    parameter int LEN_W  = ADDR_W + 3
) (
    input  logic                          clk,
    input  logic                          rst_n,

    input  logic                          cmd_valid_i,
    output logic                          cmd_ready_o,
    input  logic                          cmd_write_i,
    input  logic [ADDR_W+$clog2(NB)-1:0]  cmd_addr_i,
    input  logic [LEN_W-1:0]              cmd_len_i,

    input  logic                          wr_valid_i,
    output logic                          wr_ready_o,
    input  logic [DATA_W-1:0]             wr_data_i,

    output logic                          rd_valid_o,
    input  logic                          rd_ready_i,
    output logic [DATA_W-1:0]             rd_data_o,

    output logic                          busy_o,
    output logic                          done_o,

    output logic                          dma_write_en_o,
    output logic                          dma_read_en_o,
    output logic [$clog2(NB)-1:0]         dma_bank_sel_o,
    output logic [ADDR_W-1:0]             dma_local_addr_o,
    output logic [DATA_W-1:0]             dma_data_in_o,
    input  logic [DATA_W-1:0]             dma_rdata_i
);

    localparam int BANK_W = $clog2(NB);
    localparam int GA_W   = ADDR_W + BANK_W;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WRITE    = 3'd1,
        S_RD_ISSUE = 3'd2,
        S_RD_WAIT  = 3'd3,
        S_RD_HOLD  = 3'd4,
        S_DONE     = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [GA_W-1:0]     addr_q, addr_d;
    logic [LEN_W-1:0]    remain_q, remain_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;

    logic                last_word;

    assign last_word = (remain_q == LEN_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        remain_d       = remain_q;
        rd_data_d      = rd_data_q;
        rd_valid_d     = rd_valid_q;
        cmd_ready_o    = 1'b0;
        wr_ready_o     = 1'b0;
        done_o         = 1'b0;
        dma_write_en_o = 1'b0;
        dma_read_en_o  = 1'b0;
        dma_data_in_o  = '0;

        case (state_q)
            S_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    addr_d   = cmd_addr_i;
                    remain_d = cmd_len_i;
                    if (cmd_len_i == '0) begin
                        state_d = S_DONE;
                    end else if (cmd_write_i) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_RD_ISSUE;
                    end
                end
            end

            // Stream beats go straight to the bank in the handshake cycle.
            S_WRITE: begin
                wr_ready_o     = 1'b1;
                dma_write_en_o = wr_valid_i;
                dma_data_in_o  = wr_data_i;
                if (wr_valid_i) begin
                    addr_d   = addr_q + GA_W'(1);
                    remain_d = remain_q - LEN_W'(1);
                    if (last_word) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_RD_ISSUE: begin
                dma_read_en_o = 1'b1;
                state_d       = S_RD_WAIT;
            end

            // Address is held here so the crossbar returns data from the bank just read.
            S_RD_WAIT: begin
                rd_data_d  = dma_rdata_i;
                rd_valid_d = 1'b1;
                state_d    = S_RD_HOLD;
            end

            S_RD_HOLD: begin
                if (rd_ready_i) begin
                    rd_valid_d = 1'b0;
                    addr_d     = addr_q + GA_W'(1);
                    remain_d   = remain_q - LEN_W'(1);
                    state_d    = last_word ? S_DONE : S_RD_ISSUE;
                end
            end

            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o           = (state_q != S_IDLE);
    assign rd_valid_o       = rd_valid_q;
    assign rd_data_o        = rd_data_q;
    assign dma_bank_sel_o   = addr_q[GA_W-1:ADDR_W];
    assign dma_local_addr_o = addr_q[ADDR_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_dma_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_engine
// Purpose  : Directed bench for dma_engine with a banked-memory environment
//            and a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_engine;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int LW = 13;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [11:0]   cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid, rd_ready;
    logic [DW-1:0] rd_data;
    logic          busy, done;
    logic          dma_write_en, dma_read_en;
    logic [1:0]    dma_bank_sel;
    logic [AW-1:0] dma_local_addr;
    logic [DW-1:0] dma_data_in;
    logic [DW-1:0] dma_rdata;

    always #5 clk = ~clk;

    dma_engine #(.DATA_W(DW), .ADDR_W(AW), .NB(4), .LEN_W(LW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cmd_valid_i      (cmd_valid),
        .cmd_ready_o      (cmd_ready),
        .cmd_write_i      (cmd_write),
        .cmd_addr_i       (cmd_addr),
        .cmd_len_i        (cmd_len),
        .wr_valid_i       (wr_valid),
        .wr_ready_o       (wr_ready),
        .wr_data_i        (wr_data),
        .rd_valid_o       (rd_valid),
        .rd_ready_i       (rd_ready),
        .rd_data_o        (rd_data),
        .busy_o           (busy),
        .done_o           (done),
        .dma_write_en_o   (dma_write_en),
        .dma_read_en_o    (dma_read_en),
        .dma_bank_sel_o   (dma_bank_sel),
        .dma_local_addr_o (dma_local_addr),
        .dma_data_in_o    (dma_data_in),
        .dma_rdata_i      (dma_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Banks behind the crossbar: one-cycle read latency.
    logic [DW-1:0] bank_mem [0:4095];
    logic [DW-1:0] ref_mem  [0:4095];

    always @(posedge clk) begin
        if (dma_read_en)  dma_rdata <= bank_mem[{dma_bank_sel, dma_local_addr}];
        if (dma_write_en) bank_mem[{dma_bank_sel, dma_local_addr}] = dma_data_in;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state: addresses/data still owed by the current command.
    logic [11:0]   wq[$];
    logic [11:0]   rq[$];
    logic [DW-1:0] dq[$];
    bit            m_busy = 0, exp_done = 0, nd;
    bit            p_re = 0, p_stall = 0;
    logic [11:0]   p_addr, m_cur, m_a;
    logic [DW-1:0] p_rdata;

    int we_cnt = 0, re_cnt = 0, done_cnt = 0, acc_cnt = 0, rd_hs_total = 0, rst_act = 0;
    int acc_cyc = 0, done_cyc = 0, first_we_cyc = -1, last_we_cyc = 0, last_hs_cyc = 0, first_rv_cyc = -1;
    logic [11:0]   first_we_addr, last_we_addr;
    int            re_cyc[$];
    logic [DW-1:0] got_rd[$];

    always @(negedge clk) begin
        m_cur = {dma_bank_sel, dma_local_addr};
        if (!rst_n) begin
            wq.delete(); rq.delete(); dq.delete();
            m_busy = 0; exp_done = 0; p_re = 0; p_stall = 0;
            if (dma_write_en || dma_read_en || done) rst_act++;
        end else begin
            nd = 0;
            chk("cmd_ready", cmd_ready, !m_busy);
            chk("busy", busy, m_busy);
            chk("done", done, exp_done);
            chk("wr_ready", wr_ready, wq.size() != 0);
            chk("we_re_exclusive", dma_write_en && dma_read_en, 0);
            chk("dma_write_en", dma_write_en, wr_valid && wr_ready);
            if (!wr_ready) chk("data_in_zero", dma_data_in, 0);
            if (dq.size() == 0) chk("rd_valid_no_burst", rd_valid, 0);
            if (p_re) chk("addr_held_after_issue", m_cur, p_addr);
            if (p_stall) begin
                chk("rd_valid_hold", rd_valid, 1);
                chk("rd_data_hold", rd_data, p_rdata);
            end
            if (dma_write_en) begin
                if (first_we_cyc < 0) begin first_we_cyc = cyc; first_we_addr = m_cur; end
                last_we_cyc = cyc; last_we_addr = m_cur; we_cnt++;
            end
            if (wr_valid && wr_ready && wq.size() != 0) begin
                m_a = wq.pop_front();
                chk("wr_addr", m_cur, m_a);
                chk("wr_data", dma_data_in, wr_data);
                ref_mem[m_a] = wr_data;
                if (wq.size() == 0) nd = 1;
            end
            if (dma_read_en) begin
                re_cnt++; re_cyc.push_back(cyc);
                chk("re_while_valid", rd_valid, 0);
                chk("rd_issue_expected", rq.size() != 0, 1);
                if (rq.size() != 0) begin
                    m_a = rq.pop_front();
                    chk("rd_addr", m_cur, m_a);
                end
            end
            if (rd_valid && first_rv_cyc < 0) first_rv_cyc = cyc;
            if (rd_valid && rd_ready) begin
                rd_hs_total++; last_hs_cyc = cyc; got_rd.push_back(rd_data);
                chk("rd_beat_expected", dq.size() != 0, 1);
                if (dq.size() != 0) begin
                    chk("rd_data", rd_data, dq.pop_front());
                    if (dq.size() == 0) nd = 1;
                end
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
            p_re = dma_read_en; p_addr = m_cur;
            p_stall = rd_valid && !rd_ready; p_rdata = rd_data;
            if (exp_done) m_busy = 0;
            if (cmd_valid && cmd_ready) begin
                acc_cnt++; acc_cyc = cyc; m_busy = 1;
                if (cmd_len == 0) nd = 1;
                for (int i = 0; i < int'(cmd_len); i++) begin
                    m_a = cmd_addr + 12'(i);
                    if (cmd_write) wq.push_back(m_a);
                    else begin rq.push_back(m_a); dq.push_back(ref_mem[m_a]); end
                end
            end
            exp_done = nd;
        end
    end

    // Read sink: ready by default, stalls a chosen word for a set number of cycles.
    int stall_at = -1, stall_left = 0;
    initial begin
        rd_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (stall_left > 0 && rd_valid && rd_hs_total == stall_at) begin
                rd_ready = 1'b0; stall_left--;
            end else begin
                rd_ready = 1'b1;
            end
        end
    end

    task automatic clr();
        we_cnt = 0; re_cnt = 0; re_cyc.delete(); got_rd.delete();
        first_we_cyc = -1; first_rv_cyc = -1;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_wr_ready"}, wr_ready, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_we"}, dma_write_en, 0);
        chk({tag, "_re"}, dma_read_en, 0);
        chk({tag, "_bank"}, dma_bank_sel, 0);
        chk({tag, "_local"}, dma_local_addr, 0);
        chk({tag, "_data_in"}, dma_data_in, 0);
    endtask

    task automatic run_cmd(input bit wr, input logic [11:0] addr, input logic [LW-1:0] len,
                           input logic [DW-1:0] dbase, input bit hold);
        int g, i;
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
        g = 0;
        while (!cmd_ready && g < 50) begin @(posedge clk); #1; g++; end
        @(posedge clk); #1;
        if (hold) begin cmd_write = ~wr; cmd_addr = 12'h123; cmd_len = 5; end
        else cmd_valid = 0;
        if (wr && len != 0) begin
            i = 0; g = 0;
            while (i < int'(len) && g < 200) begin
                wr_valid = 1; wr_data = dbase + DW'(i);
                if (wr_ready) i++;
                @(posedge clk); #1; g++;
            end
            wr_valid = 0;
        end
        g = 0;
        while (!done && g < 200) begin @(posedge clk); #1; g++; end
        chk("done_seen", done, 1);
        @(posedge clk); #1;
        cmd_valid = 0;
    endtask

    int a0, d0;

    initial begin
        for (int i = 0; i < 4096; i++) begin bank_mem[i] = '0; ref_mem[i] = '0; end
        dma_rdata = '0;
        rst_n = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 0; wr_data = '0;
        #12;
        reset_checks("reset");
        @(posedge clk); #3 rst_n = 1;
        @(posedge clk); #1;

        // Write across the bank 0 -> bank 1 boundary.
        clr();
        run_cmd(1, 12'h3FE, 4, 32'hCAFE00A0, 0);
        chk("t1_we_count", we_cnt, 4);
        chk("t1_first_we_cycle", first_we_cyc - acc_cyc, 1);
        chk("t1_we_consecutive", last_we_cyc - first_we_cyc, 3);
        chk("t1_first_addr", first_we_addr, 12'h3FE);
        chk("t1_last_addr", last_we_addr, 12'h401);
        chk("t1_done_latency", done_cyc - last_we_cyc, 1);
        chk("t1_cmd_ready_after", cmd_ready, 1);

        // Read it back with the sink always ready.
        clr();
        run_cmd(0, 12'h3FE, 4, 0, 0);
        chk("t2_re_count", re_cyc.size(), 4);
        for (int i = 0; i + 1 < re_cyc.size(); i++) chk("t2_re_spacing", re_cyc[i+1] - re_cyc[i], 3);
        chk("t2_rv_latency", first_rv_cyc - re_cyc[0], 2);
        chk("t2_done_latency", done_cyc - last_hs_cyc, 1);
        chk("t2_word_count", got_rd.size(), 4);
        for (int i = 0; i < got_rd.size() && i < 4; i++) chk("t2_rd_word", got_rd[i], 32'hCAFE00A0 + i);

        // Read len 3, word 1 stalled for 5 cycles.
        clr();
        stall_at = rd_hs_total + 1; stall_left = 5;
        run_cmd(0, 12'h3FE, 3, 0, 0);
        chk("t3_re_count", re_cyc.size(), 3);
        if (re_cyc.size() == 3) begin
            chk("t3_re_spacing0", re_cyc[1] - re_cyc[0], 3);
            chk("t3_re_spacing1", re_cyc[2] - re_cyc[1], 8);
        end
        chk("t3_word_count", got_rd.size(), 3);
        for (int i = 0; i < got_rd.size() && i < 3; i++) chk("t3_rd_word", got_rd[i], 32'hCAFE00A0 + i);

        // Zero length with wr_valid toggling.
        clr();
        wr_valid = 1; wr_data = 32'hDEAD0000;
        run_cmd(1, 12'h050, 0, 0, 0);
        chk("t4_done_latency", done_cyc - acc_cyc, 1);
        for (int i = 0; i < 4; i++) begin wr_valid = ~wr_valid; @(posedge clk); #1; end
        wr_valid = 0;
        chk("t4_we_count", we_cnt, 0);
        chk("t4_re_count", re_cnt, 0);

        // Wrap of the global address space.
        clr();
        run_cmd(1, 12'hFFF, 2, 32'h00005500, 0);
        chk("t5_we_count", we_cnt, 2);
        chk("t5_first_addr", first_we_addr, 12'hFFF);
        chk("t5_last_addr", last_we_addr, 12'h000);
        clr();
        run_cmd(0, 12'hFFF, 2, 0, 0);
        chk("t5_word_count", got_rd.size(), 2);
        if (got_rd.size() == 2) chk("t5_rd_word1", got_rd[1], 32'h00005501);

        // cmd_valid held for the whole burst.
        clr();
        a0 = acc_cnt;
        run_cmd(1, 12'h020, 3, 32'h00006600, 1);
        chk("t6_accepts", acc_cnt - a0, 1);
        chk("t6_we_count", we_cnt, 3);

        // Asynchronous reset during a len-8 write.
        clr();
        cmd_valid = 1; cmd_write = 1; cmd_addr = 12'h100; cmd_len = 8;
        @(posedge clk); #1; cmd_valid = 0;
        for (int k = 0; k < 3; k++) begin
            wr_valid = 1; wr_data = 32'h00007000 + k;
            @(posedge clk); #1;
        end
        d0 = done_cnt;
        #2 rst_n = 0;
        #1 reset_checks("midrst");
        chk("t7_we_before_reset", we_cnt, 3);
        for (int k = 0; k < 2; k++) begin @(posedge clk); #1; wr_valid = ~wr_valid; end
        chk("t7_no_done", done_cnt - d0, 0);
        chk("t7_no_activity", rst_act, 0);
        #2 rst_n = 1;
        wr_valid = 0;
        @(posedge clk); #1;
        clr();
        run_cmd(1, 12'h200, 2, 32'h00008800, 0);
        chk("t7_post_we_count", we_cnt, 2);
        clr();
        run_cmd(0, 12'h100, 3, 0, 0);
        chk("t7_word_count", got_rd.size(), 3);
        for (int i = 0; i < got_rd.size() && i < 3; i++) chk("t7_rd_word", got_rd[i], 32'h00007000 + i);
        chk("t7_cmd_ready_end", cmd_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
